adpll_net_sequencer: RTL

Gain-scheduling and mode sequencer for the 2x2 NetworkRing ADPLL array, clocked on the 258 MHz fabric clock. Each node first acquires independently in PLL mode with high gains. The block then gears down to tracking gains and switches the array into network mode with the selected weight profile. It declares lock, and it re-acquires on loss of lock. It replaces the manual switch-driven kp/ki, mode and weight selection in the top level.

---
 rtl/adpll_seq_pkg.sv | 46 ++++
 rtl/ref_edge_sync.sv | 37 +++
 rtl/adpll_net_sequencer.sv | 225 ++++++++++++++++++++++
 3 files changed

// File: rtl/adpll_seq_pkg.sv
// rtl/adpll_seq_pkg.sv - shared state encoding and weight profiles for the ADPLL array sequencer
package adpll_seq_pkg;

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_ACQ    = 3'd1,
    ST_TRACK  = 3'd2,
    ST_SETTLE = 3'd3,
    ST_LOCKED = 3'd4
  } state_e;

  localparam int DIR_LEFT  = 0;
  localparam int DIR_ABOVE = 1;
  localparam int DIR_RIGHT = 2;
  localparam int DIR_BELOW = 3;

  localparam int NODE_11 = 0;
  localparam int NODE_12 = 1;
  localparam int NODE_21 = 2;
  localparam int NODE_22 = 3;

  function automatic logic [63:0] weight_field(input int node, input int dir, input logic [3:0] w);
    logic [63:0] r;
    r = 64'(w) << (16 * node + 4 * dir);
    return r;
  endfunction

  localparam logic [63:0] WEIGHTS_UNI =
      weight_field(NODE_11, DIR_LEFT, 4'd4) |
      weight_field(NODE_12, DIR_LEFT, 4'd4) |
      weight_field(NODE_21, DIR_ABOVE, 4'd4) |
      weight_field(NODE_22, DIR_LEFT, 4'd2) |
      weight_field(NODE_22, DIR_ABOVE, 4'd2);

  localparam logic [63:0] WEIGHTS_BI =
      weight_field(NODE_11, DIR_LEFT, 4'd2) |
      weight_field(NODE_11, DIR_RIGHT, 4'd1) |
      weight_field(NODE_11, DIR_BELOW, 4'd1) |
      weight_field(NODE_12, DIR_LEFT, 4'd2) |
      weight_field(NODE_12, DIR_BELOW, 4'd2) |
      weight_field(NODE_21, DIR_ABOVE, 4'd2) |
      weight_field(NODE_21, DIR_RIGHT, 4'd2) |
      weight_field(NODE_22, DIR_LEFT, 4'd2) |
      weight_field(NODE_22, DIR_ABOVE, 4'd2);

endpackage

// File: rtl/ref_edge_sync.sv
// rtl/ref_edge_sync.sv - two-flop synchroniser plus registered rising-edge strobe for the reference
module ref_edge_sync (
  input  logic clk_i,
  input  logic rst_n_i,
  input  logic ref_i,
  output logic ref_stb_o
);

  logic sync1_q, sync1_d;
  logic sync2_q, sync2_d;
  logic prev_q, prev_d;
  logic stb_q, stb_d;

  always_comb begin
    sync1_d = ref_i;
    sync2_d = sync1_q;
    prev_d  = sync2_q;
    stb_d   = sync2_q & ~prev_q;
  end

  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      sync1_q <= 1'b0;
      sync2_q <= 1'b0;
      prev_q  <= 1'b0;
      stb_q   <= 1'b0;
    end else begin
      sync1_q <= sync1_d;
      sync2_q <= sync2_d;
      prev_q  <= prev_d;
      stb_q   <= stb_d;
    end
  end

  assign ref_stb_o = stb_q;

endmodule

// File: rtl/adpll_net_sequencer.sv
// rtl/adpll_net_sequencer.sv - gain scheduling and PLL/network mode sequencing for the 2x2 ADPLL ring
module adpll_net_sequencer
  import adpll_seq_pkg::*;
#(
  parameter int PDET_WIDTH    = 5,
  parameter int KP_WIDTH      = 5,
  parameter int KI_WIDTH      = 8,
  parameter int CNT_WIDTH     = 12,
  parameter int LOCK_THRESH   = 2,
  parameter int UNLOCK_THRESH = 6,
  parameter int LOCK_COUNT    = 16,
  parameter int UNLOCK_COUNT  = 4,
  parameter int SETTLE_EDGES  = 32,
  parameter int TIMEOUT_EDGES = 4095
) (
  input  logic                    fpga_clk_i,
  input  logic                    rst_n_i,
  input  logic                    enable_i,
  input  logic                    uni_dir_i,
  input  logic                    ref_i,
  input  logic [4*PDET_WIDTH-1:0] error_i,
  input  logic [3:0]              kp_acq_i,
  input  logic [3:0]              ki_acq_i,
  input  logic [3:0]              kp_trk_i,
  input  logic [3:0]              ki_trk_i,
  output logic                    adpll_enable_o,
  output logic                    network_mode_o,
  output logic [KP_WIDTH-1:0]     kp_o,
  output logic [KI_WIDTH-1:0]     ki_o,
  output logic [63:0]             weights_o,
  output logic [2:0]              state_o,
  output logic                    locked_o,
  output logic                    timeout_o
);

  localparam logic [CNT_WIDTH-1:0]  LOCK_CNT_C    = CNT_WIDTH'(LOCK_COUNT);
  localparam logic [CNT_WIDTH-1:0]  UNLOCK_CNT_C  = CNT_WIDTH'(UNLOCK_COUNT);
  localparam logic [CNT_WIDTH-1:0]  SETTLE_CNT_C  = CNT_WIDTH'(SETTLE_EDGES);
  localparam logic [CNT_WIDTH-1:0]  TIMEOUT_CNT_C = CNT_WIDTH'(TIMEOUT_EDGES);
  localparam logic [PDET_WIDTH-1:0] LOCK_TH_C     = PDET_WIDTH'(LOCK_THRESH);
  localparam logic [PDET_WIDTH-1:0] UNLOCK_TH_C   = PDET_WIDTH'(UNLOCK_THRESH);

  // Two's-complement negate in the same width, so the most negative code reads as 2^(W-1).
  function automatic logic [PDET_WIDTH-1:0] abs_mag(input logic [PDET_WIDTH-1:0] e);
    return e[PDET_WIDTH-1] ? (~e + 1'b1) : e;
  endfunction

  function automatic logic [CNT_WIDTH-1:0] sat_inc(input logic [CNT_WIDTH-1:0] c);
    return (&c) ? c : c + 1'b1;
  endfunction

  logic                  ref_stb;
  logic                  all_in;
  logic                  any_out;
  logic [PDET_WIDTH-1:0] mag;

  state_e                state_q, state_d;
  logic [CNT_WIDTH-1:0]  lock_cnt_q, lock_cnt_d;
  logic [CNT_WIDTH-1:0]  unlock_cnt_q, unlock_cnt_d;
  logic [CNT_WIDTH-1:0]  edge_cnt_q, edge_cnt_d;
  logic                  timeout_q, timeout_d;
  logic [63:0]           weights_q, weights_d;
  logic                  en_q, en_d;
  logic                  mode_q, mode_d;
  logic                  locked_q, locked_d;
  logic [KP_WIDTH-1:0]   kp_q, kp_d;
  logic [KI_WIDTH-1:0]   ki_q, ki_d;

  ref_edge_sync u_ref_sync (
    .clk_i     (fpga_clk_i),
    .rst_n_i   (rst_n_i),
    .ref_i     (ref_i),
    .ref_stb_o (ref_stb)
  );

  always_comb begin
    all_in  = 1'b1;
    any_out = 1'b0;
    mag     = '0;
    for (int n = 0; n < 4; n++) begin
      mag = abs_mag(error_i[n*PDET_WIDTH +: PDET_WIDTH]);
      if (mag > LOCK_TH_C)   all_in  = 1'b0;
      if (mag > UNLOCK_TH_C) any_out = 1'b1;
    end
  end

  always_ff @(posedge fpga_clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      state_q      <= ST_IDLE;
      lock_cnt_q   <= '0;
      unlock_cnt_q <= '0;
      edge_cnt_q   <= '0;
      timeout_q    <= 1'b0;
      weights_q    <= '0;
      en_q         <= 1'b0;
      mode_q       <= 1'b0;
      locked_q     <= 1'b0;
      kp_q         <= '0;
      ki_q         <= '0;
    end else begin
      state_q      <= state_d;
      lock_cnt_q   <= lock_cnt_d;
      unlock_cnt_q <= unlock_cnt_d;
      edge_cnt_q   <= edge_cnt_d;
      timeout_q    <= timeout_d;
      weights_q    <= weights_d;
      en_q         <= en_d;
      mode_q       <= mode_d;
      locked_q     <= locked_d;
      kp_q         <= kp_d;
      ki_q         <= ki_d;
    end
  end

  // Thresholds are tested on the registered counters, so a transition always
  // lands one cycle after the counter reaches its limit and swallows any strobe.
  always_comb begin
    state_d      = state_q;
    lock_cnt_d   = lock_cnt_q;
    unlock_cnt_d = unlock_cnt_q;
    edge_cnt_d   = edge_cnt_q;
    timeout_d    = timeout_q;
    weights_d    = weights_q;

    case (state_q)
      ST_IDLE: begin
        if (enable_i) begin
          weights_d = uni_dir_i ? WEIGHTS_UNI : WEIGHTS_BI;
          state_d   = ST_ACQ;
        end
      end
      ST_ACQ, ST_TRACK: begin
        if (lock_cnt_q >= LOCK_CNT_C) begin
          state_d = (state_q == ST_ACQ) ? ST_TRACK : ST_SETTLE;
        end else if (edge_cnt_q >= TIMEOUT_CNT_C) begin
          timeout_d  = 1'b1;
          lock_cnt_d = '0;
          edge_cnt_d = '0;
        end else if (ref_stb) begin
          edge_cnt_d = sat_inc(edge_cnt_q);
          lock_cnt_d = all_in ? sat_inc(lock_cnt_q) : '0;
        end
      end
      ST_SETTLE: begin
        if (lock_cnt_q >= LOCK_CNT_C) begin
          state_d = ST_LOCKED;
        end else if (ref_stb) begin
          if (edge_cnt_q < SETTLE_CNT_C) begin
            edge_cnt_d = sat_inc(edge_cnt_q);
          end else begin
            lock_cnt_d = all_in ? sat_inc(lock_cnt_q) : '0;
          end
        end
      end
      ST_LOCKED: begin
        if (unlock_cnt_q >= UNLOCK_CNT_C) begin
          state_d = ST_ACQ;
        end else if (ref_stb) begin
          unlock_cnt_d = any_out ? sat_inc(unlock_cnt_q) : '0;
        end
      end
      default: state_d = ST_IDLE;
    endcase

    if (!enable_i) state_d = ST_IDLE;

    if (state_d != state_q) begin
      lock_cnt_d   = '0;
      unlock_cnt_d = '0;
      edge_cnt_d   = '0;
    end

    if (state_d == ST_IDLE) begin
      lock_cnt_d   = '0;
      unlock_cnt_d = '0;
      edge_cnt_d   = '0;
      timeout_d    = 1'b0;
      weights_d    = '0;
    end
  end

  always_comb begin
    en_d     = 1'b0;
    mode_d   = 1'b0;
    locked_d = 1'b0;
    kp_d     = '0;
    ki_d     = '0;
    case (state_d)
      ST_ACQ: begin
        en_d = 1'b1;
        kp_d = KP_WIDTH'(kp_acq_i);
        ki_d = KI_WIDTH'(ki_acq_i);
      end
      ST_TRACK: begin
        en_d = 1'b1;
        kp_d = KP_WIDTH'(kp_trk_i);
        ki_d = KI_WIDTH'(ki_trk_i);
      end
      ST_SETTLE: begin
        en_d   = 1'b1;
        mode_d = 1'b1;
        kp_d   = KP_WIDTH'(kp_trk_i);
        ki_d   = KI_WIDTH'(ki_trk_i);
      end
      ST_LOCKED: begin
        en_d     = 1'b1;
        mode_d   = 1'b1;
        locked_d = 1'b1;
        kp_d     = KP_WIDTH'(kp_trk_i);
        ki_d     = KI_WIDTH'(ki_trk_i);
      end
      default: ;
    endcase
  end

  assign adpll_enable_o = en_q;
  assign network_mode_o = mode_q;
  assign kp_o           = kp_q;
  assign ki_o           = ki_q;
  assign weights_o      = weights_q;
  assign state_o        = state_q;
  assign locked_o       = locked_q;
  assign timeout_o      = timeout_q;

endmodule
